// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate engine: shifts the latched operand by up to STEP bits per cycle,
// then presents the result with a one-cycle done pulse.
module seq_shift_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned STEP    = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [4:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             illegal_o,
    output logic [WIDTH-1:0] result_o
);

    localparam logic [4:0] OpShr  = 5'b01000;
    localparam logic [4:0] OpShra = 5'b01001;
    localparam logic [4:0] OpShl  = 5'b01010;
    localparam logic [4:0] OpRor  = 5'b01011;
    localparam logic [4:0] OpRol  = 5'b01100;

    // One extra bit so STEP == WIDTH still fits.
    localparam logic [SHAMT_W:0] StepN  = (SHAMT_W + 1)'(STEP);
    localparam logic [SHAMT_W:0] WidthN = (SHAMT_W + 1)'(WIDTH);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [4:0]         op_q, op_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               illegal_q, illegal_d;

    logic [SHAMT_W:0]   n_ext;
    logic [SHAMT_W:0]   inv_n;
    logic [WIDTH-1:0]   shifted;
    logic               op_legal;

    // Amount bits above SHAMT_W are intentionally ignored (shift is mod WIDTH).
    logic unused_b;
    assign unused_b = ^b_i[WIDTH-1:SHAMT_W];

    assign op_legal = op_i inside {OpShr, OpShra, OpShl, OpRor, OpRol};

    always_comb begin
        n_ext = ({1'b0, rem_q} > StepN) ? StepN : {1'b0, rem_q};
        inv_n = WidthN - n_ext;
        case (op_q)
            OpShr:   shifted = data_q >> n_ext;
            OpShra:  shifted = $signed(data_q) >>> n_ext;
            OpShl:   shifted = data_q << n_ext;
            OpRor:   shifted = (data_q >> n_ext) | (data_q << inv_n);
            OpRol:   shifted = (data_q << n_ext) | (data_q >> inv_n);
            default: shifted = data_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        rem_d     = rem_q;
        op_d      = op_q;
        result_d  = result_q;
        illegal_d = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start_i) begin
                    if (op_legal) begin
                        data_d  = a_i;
                        rem_d   = b_i[SHAMT_W-1:0];
                        op_d    = op_i;
                        state_d = StShift;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            StShift: begin
                if (rem_q == '0) begin
                    result_d = data_q;
                    state_d  = StDone;
                end else begin
                    data_d = shifted;
                    rem_d  = rem_q - n_ext[SHAMT_W-1:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            data_q    <= '0;
            rem_q     <= '0;
            op_q      <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            rem_q     <= rem_d;
            op_q      <= op_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    assign busy_o    = (state_q == StShift);
    assign done_o    = (state_q == StDone);
    assign illegal_o = illegal_q;
    assign result_o  = result_q;

endmodule
